// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared VRAM port widths, owner tags and arbiter states.
package vram_arbiter_pkg;
  localparam int VRAM_LINE_W = 9;
  localparam int VRAM_COL_W  = 12;
  localparam int VRAM_MODE_W = 4;
  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_RAS, OWN_CPU} owner_t;
  typedef enum logic {S_IDLE, S_BURST} state_t;
endpackage

// File: rtl/vram_arb_pick.sv
// vram_arb_pick: combinational winner select; display first, then ras/cpu with rr_cpu breaking ties.
module vram_arb_pick
  import vram_arbiter_pkg::*;
(
  input  logic   disp_req,
  input  logic   ras_req,
  input  logic   cpu_req,
  input  logic   rr_cpu,
  output owner_t win
);
  assign win = disp_req                       ? OWN_DISP :
               (ras_req && !(cpu_req && rr_cpu)) ? OWN_RAS  :
               cpu_req                        ? OWN_CPU  : OWN_NONE;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single VRAM port between display bursts, rasterizer writes and CPU accesses.
// Define VRAM_ARB_RR_EN for round-robin ras/cpu arbitration; otherwise ras has fixed priority over cpu.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int BURST_W = 8,
  parameter int DATA_W  = 24
) (
  input  logic                   clk_53_2MHz,
  input  logic                   rst_n,
  input  logic                   disp_req,
  input  logic [VRAM_LINE_W-1:0] disp_line,
  input  logic [VRAM_COL_W-1:0]  disp_col,
  input  logic [VRAM_MODE_W-1:0] disp_mode,
  input  logic [BURST_W-1:0]     disp_len,
  output logic                   disp_gnt,
  output logic                   disp_rvalid,
  output logic [DATA_W-1:0]      disp_rdata,
  input  logic                   ras_req,
  input  logic [VRAM_LINE_W-1:0] ras_line,
  input  logic [VRAM_COL_W-1:0]  ras_col,
  input  logic [VRAM_MODE_W-1:0] ras_mode,
  input  logic [DATA_W-1:0]      ras_wdata,
  output logic                   ras_gnt,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [VRAM_LINE_W-1:0] cpu_line,
  input  logic [VRAM_COL_W-1:0]  cpu_col,
  input  logic [VRAM_MODE_W-1:0] cpu_mode,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic                   cpu_gnt,
  output logic                   cpu_rvalid,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic [VRAM_LINE_W-1:0] vram_line,
  output logic [VRAM_COL_W-1:0]  vram_col,
  output logic [VRAM_MODE_W-1:0] vram_mode,
  output logic                   vram_we,
  output logic                   vram_re,
  output logic [DATA_W-1:0]      vram_wdata,
  input  logic [DATA_W-1:0]      vram_rdata,
  output logic                   busy
);
  state_t               state;
  owner_t               win, own;
  logic [BURST_W-1:0]   cnt;
  logic                 rr_cpu, arb_en;

  vram_arb_pick u_pick (
    .disp_req (disp_req),
    .ras_req  (ras_req),
    .cpu_req  (cpu_req),
    .rr_cpu   (rr_cpu),
    .win      (win)
  );

  // cnt holds the reads still to issue including the current one, so the last read frees the port
  assign arb_en = state == S_IDLE || cnt == BURST_W'(1);
  assign busy   = state == S_BURST;

`ifdef VRAM_ARB_RR_EN
  always_ff @(posedge clk_53_2MHz)
    if (!rst_n) rr_cpu <= 1'b0;
    else if (arb_en && (win == OWN_RAS || win == OWN_CPU)) rr_cpu <= win == OWN_RAS;
`else
  assign rr_cpu = 1'b0;
`endif

  always_ff @(posedge clk_53_2MHz)
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      own         <= OWN_NONE;
      disp_gnt    <= 1'b0;
      ras_gnt     <= 1'b0;
      cpu_gnt     <= 1'b0;
      disp_rvalid <= 1'b0;
      cpu_rvalid  <= 1'b0;
      disp_rdata  <= '0;
      cpu_rdata   <= '0;
      vram_line   <= '0;
      vram_col    <= '0;
      vram_mode   <= '0;
      vram_we     <= 1'b0;
      vram_re     <= 1'b0;
      vram_wdata  <= '0;
    end else begin
      disp_rvalid <= vram_re && own == OWN_DISP;
      cpu_rvalid  <= vram_re && own == OWN_CPU;
      if (vram_re && own == OWN_DISP) disp_rdata <= vram_rdata;
      if (vram_re && own == OWN_CPU) cpu_rdata <= vram_rdata;
      disp_gnt <= arb_en && win == OWN_DISP;
      ras_gnt  <= arb_en && win == OWN_RAS;
      cpu_gnt  <= arb_en && win == OWN_CPU;
      if (!arb_en) begin
        vram_col <= vram_col + 1'b1;
        cnt      <= cnt - 1'b1;
      end else begin
        state   <= win == OWN_DISP ? S_BURST : S_IDLE;
        cnt     <= win != OWN_DISP ? '0 : disp_len == '0 ? BURST_W'(1) : disp_len;
        own     <= win;
        vram_we <= win == OWN_RAS || (win == OWN_CPU && cpu_we);
        vram_re <= win == OWN_DISP || (win == OWN_CPU && !cpu_we);
        if (win != OWN_NONE) begin
          vram_line <= win == OWN_DISP ? disp_line : win == OWN_RAS ? ras_line : cpu_line;
          vram_col  <= win == OWN_DISP ? disp_col  : win == OWN_RAS ? ras_col  : cpu_col;
          vram_mode <= win == OWN_DISP ? disp_mode : win == OWN_RAS ? ras_mode : cpu_mode;
        end
        if (win == OWN_RAS || win == OWN_CPU) vram_wdata <= win == OWN_RAS ? ras_wdata : cpu_wdata;
      end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of arbitration, bursts, read return and reset of vram_arbiter.
module tb_vram_arbiter;
  logic        clk_53_2MHz = 1'b0;
  logic        rst_n;
  logic        disp_req, ras_req, cpu_req, cpu_we;
  logic [8:0]  disp_line, ras_line, cpu_line, vram_line;
  logic [11:0] disp_col, ras_col, cpu_col, vram_col;
  logic [3:0]  disp_mode, ras_mode, cpu_mode, vram_mode;
  logic [7:0]  disp_len;
  logic [23:0] ras_wdata, cpu_wdata, vram_wdata, vram_rdata, disp_rdata, cpu_rdata;
  logic        disp_gnt, ras_gnt, cpu_gnt, disp_rvalid, cpu_rvalid, vram_we, vram_re, busy;
  logic        rd_fixed;
  int          vecs = 0, errs = 0;

  always #5 clk_53_2MHz = ~clk_53_2MHz;

  // VRAM model: fixed pattern or data derived from the address being read
  assign vram_rdata = rd_fixed ? 24'hABCDEF : {3'b0, vram_line, vram_col};

  vram_arbiter #(.BURST_W(8), .DATA_W(24)) dut (
    .clk_53_2MHz (clk_53_2MHz), .rst_n (rst_n),
    .disp_req (disp_req), .disp_line (disp_line), .disp_col (disp_col), .disp_mode (disp_mode),
    .disp_len (disp_len), .disp_gnt (disp_gnt), .disp_rvalid (disp_rvalid), .disp_rdata (disp_rdata),
    .ras_req (ras_req), .ras_line (ras_line), .ras_col (ras_col), .ras_mode (ras_mode),
    .ras_wdata (ras_wdata), .ras_gnt (ras_gnt),
    .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_line (cpu_line), .cpu_col (cpu_col),
    .cpu_mode (cpu_mode), .cpu_wdata (cpu_wdata), .cpu_gnt (cpu_gnt),
    .cpu_rvalid (cpu_rvalid), .cpu_rdata (cpu_rdata),
    .vram_line (vram_line), .vram_col (vram_col), .vram_mode (vram_mode), .vram_we (vram_we),
    .vram_re (vram_re), .vram_wdata (vram_wdata), .vram_rdata (vram_rdata), .busy (busy)
  );

  task automatic cyc;
    @(negedge clk_53_2MHz);
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    cyc;
    cyc;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cyc;
    cyc;
    vecs++;
    if ({disp_gnt, ras_gnt, cpu_gnt, disp_rvalid, cpu_rvalid, vram_we, vram_re, busy} !== 8'h00) begin
      errs++;
      $display("FAIL reset_flags: got %b exp 00000000",
               {disp_gnt, ras_gnt, cpu_gnt, disp_rvalid, cpu_rvalid, vram_we, vram_re, busy});
    end
    vecs++;
    if ({vram_line, vram_col, vram_mode, vram_wdata} !== 49'h0) begin
      errs++;
      $display("FAIL reset_cmd: got %h exp 0", {vram_line, vram_col, vram_mode, vram_wdata});
    end
    vecs++;
    if ({disp_rdata, cpu_rdata} !== 48'h0) begin
      errs++;
      $display("FAIL reset_rdata: got %h exp 0", {disp_rdata, cpu_rdata});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_read;
    rd_fixed = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_line = 9'd5; cpu_col = 12'd10; cpu_mode = 4'd3;
    cpu_wdata = 24'h111111;
    cyc;
    vecs++;
    if ({cpu_gnt, ras_gnt, disp_gnt, vram_re, vram_we} !== 5'b10010) begin
      errs++;
      $display("FAIL cpu_read_gnt: got %b exp 10010", {cpu_gnt, ras_gnt, disp_gnt, vram_re, vram_we});
    end
    vecs++;
    if ({vram_line, vram_col, vram_mode} !== {9'd5, 12'd10, 4'd3}) begin
      errs++;
      $display("FAIL cpu_read_addr: got %h exp %h", {vram_line, vram_col, vram_mode}, {9'd5, 12'd10, 4'd3});
    end
    vecs++;
    if (cpu_rvalid !== 1'b0) begin
      errs++;
      $display("FAIL cpu_read_early: got %b exp 0", cpu_rvalid);
    end
    cpu_req = 1'b0;
    cyc;
    vecs++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 24'hABCDEF}) begin
      errs++;
      $display("FAIL cpu_read_data: got %b/%h exp 1/abcdef", cpu_rvalid, cpu_rdata);
    end
    vecs++;
    if ({cpu_gnt, vram_re, disp_rvalid} !== 3'b000) begin
      errs++;
      $display("FAIL cpu_read_idle: got %b exp 000", {cpu_gnt, vram_re, disp_rvalid});
    end
    cyc;
    vecs++;
    if (cpu_rvalid !== 1'b0) begin
      errs++;
      $display("FAIL cpu_read_pulse: got %b exp 0", cpu_rvalid);
    end
    rd_fixed = 1'b0;
  endtask

  task automatic test_ras_write;
    ras_req = 1'b1; ras_line = 9'd7; ras_col = 12'd20; ras_mode = 4'd1; ras_wdata = 24'h123456;
    cyc;
    vecs++;
    if ({ras_gnt, cpu_gnt, vram_we, vram_re} !== 4'b1010) begin
      errs++;
      $display("FAIL ras_write_gnt: got %b exp 1010", {ras_gnt, cpu_gnt, vram_we, vram_re});
    end
    vecs++;
    if ({vram_line, vram_col, vram_mode, vram_wdata} !== {9'd7, 12'd20, 4'd1, 24'h123456}) begin
      errs++;
      $display("FAIL ras_write_cmd: got %h exp %h", {vram_line, vram_col, vram_mode, vram_wdata},
               {9'd7, 12'd20, 4'd1, 24'h123456});
    end
    ras_req = 1'b0;
    cyc;
    vecs++;
    if ({ras_gnt, vram_we, vram_re, disp_rvalid, cpu_rvalid} !== 5'b00000) begin
      errs++;
      $display("FAIL ras_write_after: got %b exp 00000", {ras_gnt, vram_we, vram_re, disp_rvalid, cpu_rvalid});
    end
    vecs++;
    if ({vram_line, vram_col} !== {9'd7, 12'd20}) begin
      errs++;
      $display("FAIL ras_write_hold: got %h exp %h", {vram_line, vram_col}, {9'd7, 12'd20});
    end
  endtask

  task automatic test_burst_wrap;
    int nv = 0, nb = 0;
    disp_req = 1'b1; disp_line = 9'd3; disp_col = 12'd4094; disp_mode = 4'd2; disp_len = 8'd4;
    for (int i = 0; i < 7; i++) begin
      cyc;
      if (i == 0) begin
        vecs++;
        if (disp_gnt !== 1'b1) begin
          errs++;
          $display("FAIL burst_gnt: got %b exp 1", disp_gnt);
        end
        disp_req = 1'b0;
      end
      if (i < 4) begin
        vecs++;
        if ({busy, vram_re, vram_col, vram_line, vram_mode} !== {2'b11, 12'd4094 + 12'(i), 9'd3, 4'd2}) begin
          errs++;
          $display("FAIL burst_cmd_%0d: got %h exp %h", i, {busy, vram_re, vram_col, vram_line, vram_mode},
                   {2'b11, 12'd4094 + 12'(i), 9'd3, 4'd2});
        end
      end
      if (i >= 1 && i <= 4) begin
        vecs++;
        if ({disp_rvalid, disp_rdata} !== {1'b1, 3'b0, 9'd3, 12'd4094 + 12'(i - 1)}) begin
          errs++;
          $display("FAIL burst_data_%0d: got %b/%h exp 1/%h", i, disp_rvalid, disp_rdata,
                   {3'b0, 9'd3, 12'd4094 + 12'(i - 1)});
        end
      end
      nv += int'(disp_rvalid);
      nb += int'(busy);
    end
    vecs++;
    if (nv != 4 || nb != 4) begin
      errs++;
      $display("FAIL burst_counts: got rvalid %0d busy %0d exp 4 4", nv, nb);
    end
  endtask

  task automatic test_simultaneous;
    apply_reset;
    disp_req = 1'b1; disp_line = 9'd1; disp_col = 12'd100; disp_mode = 4'd0; disp_len = 8'd2;
    ras_req = 1'b1; ras_line = 9'd2; ras_col = 12'd200; ras_wdata = 24'hAAAAAA;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_line = 9'd3; cpu_col = 12'd300; cpu_wdata = 24'h555555;
    cyc;
    vecs++;
    if ({disp_gnt, ras_gnt, cpu_gnt, busy} !== 4'b1001) begin
      errs++;
      $display("FAIL simul_disp_first: got %b exp 1001", {disp_gnt, ras_gnt, cpu_gnt, busy});
    end
    disp_req = 1'b0;
    cyc;
    vecs++;
    if ({disp_gnt, ras_gnt, cpu_gnt, busy, vram_col} !== {4'b0001, 12'd101}) begin
      errs++;
      $display("FAIL simul_burst_wait: got %h exp %h", {disp_gnt, ras_gnt, cpu_gnt, busy, vram_col},
               {4'b0001, 12'd101});
    end
    cyc;
    vecs++;
    if ({ras_gnt, cpu_gnt, busy, vram_we, vram_line, vram_col} !== {4'b1001, 9'd2, 12'd200}) begin
      errs++;
      $display("FAIL simul_ras: got %h exp %h", {ras_gnt, cpu_gnt, busy, vram_we, vram_line, vram_col},
               {4'b1001, 9'd2, 12'd200});
    end
    ras_req = 1'b0;
    cyc;
    vecs++;
    if ({ras_gnt, cpu_gnt, vram_we, vram_line, vram_wdata} !== {3'b011, 9'd3, 24'h555555}) begin
      errs++;
      $display("FAIL simul_cpu: got %h exp %h", {ras_gnt, cpu_gnt, vram_we, vram_line, vram_wdata},
               {3'b011, 9'd3, 24'h555555});
    end
    cpu_req = 1'b0;
    cyc;
    vecs++;
    if ({ras_gnt, cpu_gnt, vram_we} !== 3'b000) begin
      errs++;
      $display("FAIL simul_done: got %b exp 000", {ras_gnt, cpu_gnt, vram_we});
    end
  endtask

  task automatic test_contention;
    logic [1:0] exp;
    apply_reset;
    ras_req = 1'b1; ras_line = 9'd8; ras_col = 12'd1; ras_wdata = 24'h0000AA;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_line = 9'd9; cpu_col = 12'd2; cpu_wdata = 24'h0000BB;
    for (int i = 0; i < 4; i++) begin
      cyc;
`ifdef VRAM_ARB_RR_EN
      exp = (i % 2 == 1) ? 2'b01 : 2'b10;
`else
      exp = 2'b10;
`endif
      vecs++;
      if ({ras_gnt, cpu_gnt} !== exp) begin
        errs++;
        $display("FAIL contention_gnt_%0d: got %b exp %b", i, {ras_gnt, cpu_gnt}, exp);
      end
      vecs++;
      if (vram_line !== (exp == 2'b10 ? 9'd8 : 9'd9)) begin
        errs++;
        $display("FAIL contention_line_%0d: got %0d exp %0d", i, vram_line, exp == 2'b10 ? 9'd8 : 9'd9);
      end
    end
    ras_req = 1'b0;
    cpu_req = 1'b0;
    cyc;
    cyc;
    vecs++;
    if ({ras_gnt, cpu_gnt} !== 2'b00) begin
      errs++;
      $display("FAIL contention_idle: got %b exp 00", {ras_gnt, cpu_gnt});
    end
  endtask

  task automatic test_len0;
    int nv = 0;
    disp_req = 1'b1; disp_line = 9'd4; disp_col = 12'd50; disp_mode = 4'd7; disp_len = 8'd0;
    cyc;
    vecs++;
    if ({disp_gnt, busy, vram_re, vram_col} !== {3'b111, 12'd50}) begin
      errs++;
      $display("FAIL len0_gnt: got %h exp %h", {disp_gnt, busy, vram_re, vram_col}, {3'b111, 12'd50});
    end
    disp_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc;
      if (i == 0) begin
        vecs++;
        if ({busy, vram_re, disp_rvalid, disp_rdata} !== {3'b001, 3'b0, 9'd4, 12'd50}) begin
          errs++;
          $display("FAIL len0_read: got %h exp %h", {busy, vram_re, disp_rvalid, disp_rdata},
                   {3'b001, 3'b0, 9'd4, 12'd50});
        end
      end
      nv += int'(disp_rvalid);
    end
    vecs++;
    if (nv != 1) begin
      errs++;
      $display("FAIL len0_count: got %0d exp 1", nv);
    end
  endtask

  task automatic test_reset_mid_burst;
    int n = 0;
    disp_req = 1'b1; disp_line = 9'd6; disp_col = 12'd0; disp_mode = 4'd5; disp_len = 8'd8;
    cyc;
    disp_req = 1'b0;
    cyc;
    cyc;
    vecs++;
    if ({busy, vram_re, vram_col} !== {2'b11, 12'd2}) begin
      errs++;
      $display("FAIL midrst_third: got %h exp %h", {busy, vram_re, vram_col}, {2'b11, 12'd2});
    end
    rst_n = 1'b0;
    cyc;
    vecs++;
    if ({disp_gnt, disp_rvalid, busy, vram_re, vram_we, vram_line, vram_col, vram_mode, disp_rdata} !== 56'h0) begin
      errs++;
      $display("FAIL midrst_clear: got %h exp 0",
               {disp_gnt, disp_rvalid, busy, vram_re, vram_we, vram_line, vram_col, vram_mode, disp_rdata});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc;
      n += int'(disp_rvalid) + int'(busy) + int'(vram_re);
    end
    vecs++;
    if (n != 0) begin
      errs++;
      $display("FAIL midrst_quiet: got %0d active cycles exp 0", n);
    end
  endtask

  initial begin
    rst_n = 1'b0; rd_fixed = 1'b0;
    disp_req = 1'b0; disp_line = '0; disp_col = '0; disp_mode = '0; disp_len = '0;
    ras_req = 1'b0; ras_line = '0; ras_col = '0; ras_mode = '0; ras_wdata = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_line = '0; cpu_col = '0; cpu_mode = '0; cpu_wdata = '0;
    test_reset;
    test_cpu_read;
    test_ras_write;
    test_burst_wrap;
    test_simultaneous;
    test_contention;
    test_len0;
    test_reset_mid_burst;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Arbiter and sequencer for the GPU's single VRAM access port. Shares the port between three requesters: display scan-out (burst reads), rasterizer (writes), and CPU/DMA transfer (reads or writes). Issues one VRAM access per cycle with registered VRAM-side signals. Returns read data with fixed latency.

## Interface
Parameters:
- BURST_W, 8, width of display burst length field
- DATA_W, 24, VRAM data width (matches VRAM port)

Ports:
- clk_53_2MHz  in  1  system clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- disp_req / disp_line / disp_col / disp_mode / disp_len  in  1/9/12/4/BURST_W  display burst request: start line, column, mode, word count
- disp_gnt  out  1  one-cycle pulse; burst accepted
- disp_rvalid / disp_rdata  out  1/DATA_W  one read word per pulse
- ras_req / ras_line / ras_col / ras_mode / ras_wdata  in  1/9/12/4/DATA_W  rasterizer write request
- ras_gnt  out  1  one-cycle pulse; write issued
- cpu_req / cpu_we / cpu_line / cpu_col / cpu_mode / cpu_wdata  in  1/1/9/12/4/DATA_W  CPU single access
- cpu_gnt  out  1  one-cycle pulse; access issued
- cpu_rvalid / cpu_rdata  out  1/DATA_W  CPU read return
- vram_line / vram_col / vram_mode / vram_we / vram_re / vram_wdata  out  9/12/4/1/1/DATA_W  registered VRAM command
- vram_rdata  in  DATA_W  VRAM combinational read data
- busy  out  1  high while in BURST state

## Operation
- States: IDLE, BURST. All requests are level: a requester holds req and fields stable until it sees its gnt pulse. It may re-assert req in the cycle after gnt.
- IDLE, arbitration each edge. disp_req has absolute priority. Otherwise ras vs cpu is resolved by the policy in Configuration. The winner gets gnt=1 for the next cycle, and its fields load into the vram_* registers. vram_we=1 for ras, or for cpu with cpu_we. vram_re=1 otherwise. With no requester, vram_we=vram_re=0 and the other vram_* outputs hold their values.
- Display win: loads burst counter with disp_len (0 treated as 1). State becomes BURST. The first read is issued in the gnt cycle.
- BURST: one read per cycle.
  - vram_col increments by 1 each cycle, 12-bit wrap (4095 -> 0).
  - Line and mode are held.
  - Counter decrements per read.
  - After the last read the state returns to IDLE, and arbitration resumes at that edge.
  - ras/cpu requests wait and are never dropped.
- Read return: vram_rdata is captured at the end of each cycle with vram_re=1 and routed to disp or cpu by an owner tag. The matching rvalid is high for exactly the following cycle.
- The arbiter never modifies line/col/mode; address transform is the VRAM's job.
- Reset (mid-burst included): state IDLE, counter 0, all gnt/rvalid/busy/vram_we/vram_re = 0, vram_line/col/mode/wdata = 0, rdata outputs = 0, RR pointer = ras. Any in-flight burst is abandoned and no rvalid is emitted for it.

## Timing
- Request seen at edge E -> gnt, vram_* command valid during cycle E+1.
- Write committed by VRAM at edge E+2.
- Read: rvalid/rdata valid during cycle E+2 (latency 2 from request sample).
- Display burst of N: rvalid in cycles E+2 .. E+N+1, back-to-back. busy is high cycles E+1 .. E+N.
- Throughput: one access per cycle. A new grant can be issued on the edge that ends a single access or ends a burst.
- Simultaneous disp/ras/cpu at IDLE: disp wins, and ras/cpu are served after the burst.

## Configuration
- VRAM_ARB_RR_EN
  - Defined: ras vs cpu alternates by round-robin. The pointer flips to the other requester after each ras or cpu grant.
  - Undefined: fixed priority ras > cpu, and no pointer register exists.
- Display priority is unchanged in both builds.

## Structure
- Shared GPU package: owner enum (OWN_NONE, OWN_DISP, OWN_RAS, OWN_CPU), state enum (S_IDLE, S_BURST), VRAM_LINE_W=9, VRAM_COL_W=12, VRAM_MODE_W=4.
- One natural sub-module: vram_arb_pick, the combinational winner select incl. RR pointer input. Burst counter, command registers and return path stay in vram_arbiter.

## Test plan
- Reset mid-burst: disp_len=8, rst_n low at 3rd read -> next cycle all outputs 0, no further disp_rvalid, state IDLE.
- CPU read: cpu_req, cpu_we=0, line=5, col=10, VRAM returning 24'hABCDEF -> cpu_gnt at E+1 with vram_re=1, line 5, col 10; cpu_rvalid=1, cpu_rdata=24'hABCDEF at E+2.
- Display burst wrap: disp_col=4094, disp_len=4 -> vram_col 4094, 4095, 0, 1; four consecutive disp_rvalid; busy for 4 cycles.
- Simultaneous disp+ras+cpu -> disp_gnt first; ras/cpu grants only after the burst ends, with no request lost.
- Contention policy: ras and cpu held continuously for 4 grants.
  - With VRAM_ARB_RR_EN: grants ras, cpu, ras, cpu.
  - Without: ras, ras, ras, ras.
- disp_len=0 -> exactly one read and one disp_rvalid, back to IDLE.
